sisc_mem_arbiter: RTL

- Shares one single-port unified memory between two requesters on the SISC computer.
- The instruction-fetch port feeds the IR during fetch; the data port serves LOD/STR during the mem state.
- Multi-cycle sequencer: arbitrates round-robin, holds the granted request stable for the memory latency, then returns read data with a one-cycle acknowledge.
- The control FSM stalls on the ack instead of assuming single-cycle memory.

---
 rtl/sisc_mem_arbiter_pkg.sv | 22 ++
 rtl/sisc_mem_arbiter_rr_arb2.sv | 23 ++
 rtl/sisc_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sisc_mem_arbiter_pkg.sv
// Shared definitions for the SISC unified-memory arbiter: widths, state and grant encodings.
package sisc_mem_arbiter_pkg;

    localparam int unsigned SiscAddrW = 16;
    localparam int unsigned SiscDataW = 32;
    localparam int unsigned CntW      = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StAccess = 2'd1;
    localparam state_t StResp   = 2'd2;

    localparam logic GrantI = 1'b0;
    localparam logic GrantD = 1'b1;

    // Starting value of the ACCESS countdown; the access ends when it reaches zero.
    function automatic logic [CntW-1:0] lat_init(input int unsigned lat);
        return CntW'(lat - 1);
    endfunction

endpackage

// File: rtl/sisc_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_arb2
    import sisc_mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = GrantD;
        end else begin
            grant_id = GrantI;
        end
    end

endmodule

// File: rtl/sisc_mem_arbiter.sv
// Multi-cycle sequencer sharing one single-port memory between the fetch and data ports.
module sisc_mem_arbiter
    import sisc_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = SiscAddrW,
    parameter int unsigned DATA_W  = SiscDataW,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_valid;
    logic grant_id;

    rr_arb2 u_rr_arb2 (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant_d = grant_id;
                    if (grant_id == GrantD) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    cnt_d   = lat_init(MEM_LAT);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    // Stores leave d_rdata untouched.
                    if (grant_q == GrantI) begin
                        i_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= GrantD;
            grant_q      <= GrantD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Decoded from state so an asynchronous reset drops them without a clock edge.
    assign mem_en    = (state_q == StAccess);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign i_ack     = (state_q == StResp) && (grant_q == GrantI);
    assign d_ack     = (state_q == StResp) && (grant_q == GrantD);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
